scm_write_arbiter: RTL and testbench
====================================

# scm_write_arbiter

Write-side front end for the latch-based multi-port-read register file. Merges `N_PORTS` independent write requesters into the single write port (`WriteEnable`/`WriteAddr`/`WriteData`) through per-port FIFOs and a round-robin arbiter. Provides a combinational pending-write hazard check so read-side logic can hold off a read whose address has an in-flight write.

## Interface
Parameters:
- `ADDR_WIDTH`, 5, word address width; must match the register file.
- `DATA_WIDTH`, 32, word width.
- `N_PORTS`, 2, number of write requesters, 2..8.
- `FIFO_DEPTH`, 2, entries per port FIFO; power of two, ≥2.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid_i`  in  N_PORTS  per-port write request valid.
- `req_ready_o`  out  N_PORTS  per-port accept; registered.
- `req_addr_i`  in  N_PORTS*ADDR_WIDTH  packed per-port addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data_i`  in  N_PORTS*DATA_WIDTH  packed per-port data.
- `stall_i`  in  1  inhibits grants; FIFOs still accept while not full.
- `we_o`  out  1  to register file `WriteEnable`.
- `waddr_o`  out  ADDR_WIDTH  to `WriteAddr`.
- `wdata_o`  out  DATA_WIDTH  to `WriteData`.
- `chk_addr_i`  in  ADDR_WIDTH  address to test for pending writes.
- `chk_hit_o`  out  1  combinational hazard flag.

## Operation
- Per-port FIFO: circular buffer with read/write pointers and an occupancy counter of width clog2(FIFO_DEPTH)+1.
- Push on port p when `req_valid_i[p] && req_ready_o[p]` at a rising edge.
- `req_ready_o[p]` = (count_p != FIFO_DEPTH), registered. No full-with-pop bypass: a full FIFO deasserts ready even in a cycle where it is popped.
- Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
- Arbiter:
  - Each cycle with `stall_i`=0, exactly one non-empty FIFO is granted, in round-robin order starting at `rr_ptr`.
  - The granted head is popped and loaded into the output registers.
  - After a grant to port g, `rr_ptr` = (g+1) mod N_PORTS. With no grant, `rr_ptr` holds.
- Output registers: `we_o` is 1 in the cycle after a grant and 0 otherwise. `waddr_o`/`wdata_o` update only on a grant and hold their last value when `we_o`=0.
- Ordering:
  - Writes from the same port leave in acceptance order.
  - Across ports, writes leave in round-robin grant order. Two ports writing the same address in the same cycle: the later grant wins in the register file.
- `chk_hit_o` = 1 if `chk_addr_i` equals the address of any occupied FIFO entry, or equals `waddr_o` while `we_o`=1. It does not include the register file's internal write-data stage.
- Pointer wrap: FIFO pointers wrap modulo FIFO_DEPTH. Counters never exceed FIFO_DEPTH or go below 0.

## Timing
- Reset values: `req_ready_o` all 1, `we_o` 0, `waddr_o` 0, `wdata_o` 0, all counts and pointers 0, `rr_ptr` 0. `chk_hit_o` is therefore 0 during reset.
- Assertion of `rst` clears state immediately, mid-burst included. Words in flight are dropped and no partial write is emitted.
- Best-case latency: a request accepted at edge E0 is granted in the cycle after E0, and `we_o`=1 in the cycle after E1. The register file samples it at E2.
- Throughput: one write per cycle aggregate. With all ports saturated, each port gets 1/N_PORTS.
- `stall_i` is sampled combinationally in the grant cycle. `stall_i`=1 at edge E forces `we_o`=0 after E.
- `chk_hit_o` responds to `chk_addr_i` in the same cycle. It reflects FIFO state as of the last edge.

## Test plan
- Reset/idle:
  - Assert `rst` asynchronously mid-cycle → `we_o`=0 and `req_ready_o`=all-ones immediately.
  - After release with no requests → `we_o` stays 0 for 20 cycles.
- Single write:
  - Port 0 pushes addr 5, data 0xDEADBEEF at E0 → `we_o`=1, `waddr_o`=5, `wdata_o`=0xDEADBEEF after E1 only.
  - `chk_hit_o`=1 for `chk_addr_i`=5 between E0 and E2, and 0 afterwards.
- Round robin:
  - Both ports push continuously, port 0 addresses 0,1,2 and port 1 addresses 16,17,18 → `waddr_o` sequence 0,16,1,17,2,18 with no idle cycles.
- Full/backpressure (FIFO_DEPTH=2):
  - `stall_i`=1 while port 1 pushes 3 words → `req_ready_o[1]`=0 after the 2nd accept and the 3rd word is held.
  - Release `stall_i` → words emitted in order and ready reasserts one cycle after the first pop.
- Wrap-around and simultaneous push/pop:
  - 10 back-to-back writes on port 0 only → 10 `we_o` pulses with data and addresses in order, counter stable at 1, no loss across pointer wrap.
- Reset mid-burst:
  - Port 0 has 2 queued, assert `rst` → no further `we_o` pulses, `chk_hit_o`=0 for all addresses.

Source files
------------

// File: rtl/scm_write_arbiter.sv
// Write-side front end for the latch-based register file: per-port FIFOs merged
// through a round-robin arbiter onto one write port, plus a pending-write hazard check.
module scm_write_arbiter #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned N_PORTS    = 2,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_PORTS-1:0]            req_valid_i,
    output logic [N_PORTS-1:0]            req_ready_o,
    input  logic [N_PORTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [N_PORTS*DATA_WIDTH-1:0] req_data_i,
    input  logic                          stall_i,
    output logic                          we_o,
    output logic [ADDR_WIDTH-1:0]         waddr_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    input  logic [ADDR_WIDTH-1:0]         chk_addr_i,
    output logic                          chk_hit_o
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = $clog2(N_PORTS);

    logic [ADDR_WIDTH-1:0] addr_mem_q [N_PORTS][FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem_d [N_PORTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_q [N_PORTS][FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] data_mem_d [N_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q [N_PORTS];
    logic [PTR_W-1:0]      rd_ptr_d [N_PORTS];
    logic [PTR_W-1:0]      wr_ptr_q [N_PORTS];
    logic [PTR_W-1:0]      wr_ptr_d [N_PORTS];
    logic [CNT_W-1:0]      cnt_q [N_PORTS];
    logic [CNT_W-1:0]      cnt_d [N_PORTS];
    logic [N_PORTS-1:0]    ready_q, ready_d;
    logic [RR_W-1:0]       rr_q, rr_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic                  gnt_valid;
    logic [RR_W-1:0]       gnt_idx;

    // Round-robin search: first non-empty FIFO at or after rr_q, wrapping.
    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx = 32'(rr_q) + i;
            if (idx >= N_PORTS) idx = idx - N_PORTS;
            if (!stall_i && !gnt_valid && cnt_q[RR_W'(idx)] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = RR_W'(idx);
            end
        end
    end

    always_comb begin
        logic push;
        logic pop;
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        push       = 1'b0;
        pop        = 1'b0;
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            push = req_valid_i[p] && ready_q[p];
            pop  = gnt_valid && (gnt_idx == RR_W'(p));
            if (push) begin
                addr_mem_d[p][wr_ptr_q[p]] = req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                data_mem_d[p][wr_ptr_q[p]] = req_data_i[p*DATA_WIDTH +: DATA_WIDTH];
                wr_ptr_d[p] = wr_ptr_q[p] + PTR_W'(1);
            end
            if (pop) rd_ptr_d[p] = rd_ptr_q[p] + PTR_W'(1);
            case ({push, pop})
                2'b10:   cnt_d[p] = cnt_q[p] + CNT_W'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CNT_W'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
            // Ready tracks the post-edge count, so a full FIFO stays not-ready in its pop cycle.
            ready_d[p] = (cnt_d[p] != CNT_W'(FIFO_DEPTH));
        end
    end

    always_comb begin
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rr_d    = rr_q;
        if (gnt_valid) begin
            we_d    = 1'b1;
            waddr_d = addr_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
            wdata_d = data_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
            rr_d    = (32'(gnt_idx) == N_PORTS - 1) ? '0 : gnt_idx + RR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                    addr_mem_q[p][e] <= '0;
                    data_mem_q[p][e] <= '0;
                end
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            ready_q <= '1;
            rr_q    <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            addr_mem_q <= addr_mem_d;
            data_mem_q <= data_mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            rr_q       <= rr_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    // An entry is live when its offset from the read pointer is below the occupancy.
    always_comb begin
        logic [PTR_W-1:0] off;
        off       = '0;
        chk_hit_o = we_q && (waddr_q == chk_addr_i);
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                off = PTR_W'(e) - rd_ptr_q[p];
                if (({1'b0, off} < cnt_q[p]) && (addr_mem_q[p][e] == chk_addr_i))
                    chk_hit_o = 1'b1;
            end
        end
    end

    assign req_ready_o = ready_q;
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;

endmodule

// File: tb/tb_scm_write_arbiter.sv
// Scoreboard bench for scm_write_arbiter: directed stimulus pushes expected writes,
// a negedge monitor pops and compares every we_o pulse.
module tb_scm_write_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [63:0] req_data;
    logic        stall;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  chk_addr;
    logic        chk_hit;

    int n_cmp = 0;
    int n_err = 0;

    logic [4:0]  exp_a [$];
    logic [31:0] exp_d [$];
    logic [4:0]  qa0 [$];
    logic [4:0]  qa1 [$];
    logic [31:0] qd0 [$];
    logic [31:0] qd1 [$];
    logic [31:0] we_hist, rdy0_hist, rdy1_hist;

    scm_write_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .N_PORTS(2), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_addr_i(req_addr), .req_data_i(req_data),
        .stall_i(stall),
        .we_o(we), .waddr_o(waddr), .wdata_o(wdata),
        .chk_addr_i(chk_addr), .chk_hit_o(chk_hit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && we) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", waddr, wdata);
            end else begin
                chk("sb_waddr", 64'(waddr), 64'(exp_a.pop_front()));
                chk("sb_wdata", 64'(wdata), 64'(exp_d.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_a.push_back(a);
        exp_d.push_back(d);
    endtask

    task automatic do_reset();
        req_valid = '0;
        stall     = 1'b0;
        rst       = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Handshake-aware driver: a port advances to its next word only once accepted.
    task automatic drive(input int n);
        logic [1:0] acc;
        we_hist = '0; rdy0_hist = '0; rdy1_hist = '0;
        for (int k = 0; k < n; k++) begin
            if (qa0.size() > 0) begin
                req_valid[0] = 1'b1; req_addr[4:0] = qa0[0]; req_data[31:0] = qd0[0];
            end else req_valid[0] = 1'b0;
            if (qa1.size() > 0) begin
                req_valid[1] = 1'b1; req_addr[9:5] = qa1[0]; req_data[63:32] = qd1[0];
            end else req_valid[1] = 1'b0;
            acc = req_valid & req_ready;
            cyc();
            if (acc[0]) begin void'(qa0.pop_front()); void'(qd0.pop_front()); end
            if (acc[1]) begin void'(qa1.pop_front()); void'(qd1.pop_front()); end
            we_hist[k]   = we;
            rdy0_hist[k] = req_ready[0];
            rdy1_hist[k] = req_ready[1];
        end
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; stall = 1'b0; chk_addr = '0;
        #2;
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'h3);
        chk("rst_waddr", 64'(waddr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_hit", 64'(chk_hit), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("idle_we", 64'(we), 64'd0);
        end

        // Single write on port 0
        req_valid[0] = 1'b1; req_addr[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
        expect_wr(5'd5, 32'hDEADBEEF);
        cyc();
        req_valid = '0;
        chk_addr  = 5'd5;
        #1;
        chk("single_we_e0", 64'(we), 64'd0);
        chk("single_hit_e0", 64'(chk_hit), 64'd1);
        cyc();
        chk("single_we_e1", 64'(we), 64'd1);
        chk("single_waddr", 64'(waddr), 64'd5);
        chk("single_wdata", 64'(wdata), 64'hDEADBEEF);
        chk("single_hit_e1", 64'(chk_hit), 64'd1);
        cyc();
        chk("single_we_e2", 64'(we), 64'd0);
        chk("single_hit_e2", 64'(chk_hit), 64'd0);
        chk("single_hold_waddr", 64'(waddr), 64'd5);

        // Round robin, both ports saturated
        do_reset();
        for (int i = 0; i < 3; i++) begin
            qa0.push_back(5'(i));      qd0.push_back(32'hA000_0000 + 32'(i));
            qa1.push_back(5'(16 + i)); qd1.push_back(32'hB000_0010 + 32'(i));
        end
        for (int i = 0; i < 3; i++) begin
            expect_wr(5'(i), 32'hA000_0000 + 32'(i));
            expect_wr(5'(16 + i), 32'hB000_0010 + 32'(i));
        end
        drive(10);
        chk("rr_we_pattern", 64'(we_hist[9:0]), 64'h07E);

        // Backpressure with stall
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            qa1.push_back(5'(8 + i)); qd1.push_back(32'h1111_0008 + 32'(i));
            expect_wr(5'(8 + i), 32'h1111_0008 + 32'(i));
        end
        drive(4);
        chk("bp_stall_we", 64'(we_hist[3:0]), 64'h0);
        chk("bp_ready1", 64'(rdy1_hist[3:0]), 64'h1);
        chk("bp_held", 64'(qa1.size()), 64'd1);
        stall = 1'b0;
        drive(5);
        chk("bp_release_we", 64'(we_hist[4:0]), 64'h07);
        chk("bp_release_ready1", 64'(rdy1_hist[4:0]), 64'h1F);

        // Wrap-around with simultaneous push/pop on port 0
        do_reset();
        for (int i = 0; i < 10; i++) begin
            qa0.push_back(5'(20 + i)); qd0.push_back(32'hC0DE_0000 + 32'(i));
            expect_wr(5'(20 + i), 32'hC0DE_0000 + 32'(i));
        end
        drive(14);
        chk("wrap_we_pattern", 64'(we_hist[13:0]), 64'h7FE);
        chk("wrap_ready0", 64'(rdy0_hist[13:0]), 64'h3FFF);

        // Reset mid-burst; these words are dropped so nothing is expected
        do_reset();
        stall = 1'b1;
        qa0.push_back(5'd3); qd0.push_back(32'h3333_3333);
        qa0.push_back(5'd4); qd0.push_back(32'h4444_4444);
        drive(2);
        chk_addr = 5'd3; #1;
        chk("mid_hit3", 64'(chk_hit), 64'd1);
        chk_addr = 5'd4; #1;
        chk("mid_hit4", 64'(chk_hit), 64'd1);
        stall = 1'b0;
        @(posedge clk); #1;
        chk("mid_we_before_rst", 64'(we), 64'd1);
        chk("mid_waddr_before_rst", 64'(waddr), 64'd3);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we", 64'(we), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'h3);
        for (int a = 0; a < 32; a++) begin
            chk_addr = 5'(a);
            #1;
            chk("mid_rst_hit", 64'(chk_hit), 64'd0);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("post_rst_we", 64'(we), 64'd0);
        end

        chk("sb_drained", 64'(exp_a.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
